// File: rtl/imc_shift_accumulator_if.sv
// Handshake bundle for imc_shift_accumulator: bit-plane input, drained word output, status.
// slave = accumulator side, master = the block feeding planes and draining words.
interface imc_shift_accumulator_if #(
  parameter int COLS  = 16,
  parameter int ADC_W = 4,
  parameter int ACC_W = 16
);
  logic                    start;
  logic                    adc_valid;
  logic                    adc_ready;
  logic [COLS*ADC_W-1:0]   adc_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*ACC_W-1:0]      out_data;
  logic                    busy;
  logic                    done;

  modport master (
    output start, adc_valid, adc_data, out_ready,
    input  adc_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, adc_valid, adc_data, out_ready,
    output adc_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/imc_shift_accumulator.sv
// Shift-add accumulation of CIM ADC bit-planes (MSB first) into per-column sums, drained two columns per word.
// Define IMC_ACC_SIGNED_EN for two's-complement activations (MSB plane carries negative weight).
module imc_shift_accumulator #(
  parameter int COLS    = 16,
  parameter int ADC_W   = 4,
  parameter int IN_BITS = 8,
  parameter int ACC_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  imc_shift_accumulator_if.slave bus
);

  localparam int NWORDS = COLS / 2;
  localparam int PW     = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam int WW     = (NWORDS > 1)  ? $clog2(NWORDS)  : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     plane_cnt;
  logic [WW-1:0]     word_idx;
  logic              done_q;
  logic [ACC_W-1:0]  acc   [COLS];
  logic [ACC_W-1:0]  acc_d [COLS];

  logic              adc_beat, out_beat, last_plane, last_word;
  logic [WW:0]       lo_sel, hi_sel;

  assign adc_beat   = bus.adc_valid & (state_q == ACCUM);
  assign out_beat   = bus.out_ready & (state_q == DRAIN);
  assign last_plane = (plane_cnt == PW'(IN_BITS - 1));
  assign last_word  = (word_idx == WW'(NWORDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)              state_d = ACCUM;
      ACCUM:   if (adc_beat && last_plane) state_d = DRAIN;
      DRAIN:   if (out_beat && last_word)  state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
`ifdef IMC_ACC_SIGNED_EN
      // MSB plane is the sign plane: start from its negated contribution.
      if (plane_cnt == '0)
        acc_d[c] = '0 - ACC_W'(bus.adc_data[c*ADC_W +: ADC_W]);
      else
        acc_d[c] = (acc[c] << 1) + ACC_W'(bus.adc_data[c*ADC_W +: ADC_W]);
`else
      acc_d[c] = (acc[c] << 1) + ACC_W'(bus.adc_data[c*ADC_W +: ADC_W]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      plane_cnt <= '0;
      word_idx  <= '0;
      done_q    <= 1'b0;
      for (int unsigned c = 0; c < COLS; c++) acc[c] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= out_beat & last_word;
      if (state_q == IDLE && bus.start) begin
        plane_cnt <= '0;
        word_idx  <= '0;
        for (int unsigned c = 0; c < COLS; c++) acc[c] <= '0;
      end
      if (adc_beat) begin
        plane_cnt <= plane_cnt + 1'b1;
        for (int unsigned c = 0; c < COLS; c++) acc[c] <= acc_d[c];
      end
      if (out_beat) word_idx <= last_word ? '0 : word_idx + 1'b1;
    end
  end

  assign lo_sel = {word_idx, 1'b0};
  assign hi_sel = {word_idx, 1'b1};

  assign bus.adc_ready = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_data  = {acc[hi_sel], acc[lo_sel]};

endmodule
